// File: rtl/uart_pkg.sv
// Shared types and constants for the shared-UART transmit path: FSM state encoding,
// default bit timing, and a helper that derives the sample-tick divider from clock and baud.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_CLK_DIV    = 326;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_W     = 8;

  // Rounded to nearest: 50 MHz / (9600 * 16) = 325.52 -> 326.
  function automatic int calc_clk_div(input int clk_hz, input int baud, input int oversample);
    int tick_hz;
    tick_hz = baud * oversample;
    return (clk_hz + tick_hz / 2) / tick_hz;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-request handshake between two requesters and the shared UART transmitter.
// master = requester side, slave = arbiter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Sample-tick clock enable: counts 0..CLK_DIV-1 while enabled and pulses tick for one
// cycle on the terminal count. clr restarts the count so a new frame gets full-length bits.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clkin,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clkin) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single 8N1 transmitter with
// OVERSAMPLE sample ticks per bit. Arbitration, FSM and shifter live here.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic             clkin,
  input  logic             rst,
  uart_tx_arbiter_if.slave req,
  output logic             txd,
  output logic             busy,
  output logic             grant
);
  localparam int               OS_W     = $clog2(OVERSAMPLE);
  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;

  logic idle, sel0, sel1, accept, tick;

  // On a tie the requester that did not own the previous frame wins.
  always_comb begin
    idle           = (state_q == IDLE);
    sel1           = req.req1_valid && (!req.req0_valid || !last_grant_q);
    sel0           = req.req0_valid && !sel1;
    req.req0_ready = !rst && idle && sel0;
    req.req1_ready = !rst && idle && sel1;
    accept         = req.req0_ready || req.req1_ready;
  end

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clkin (clkin),
    .rst   (rst),
    .clr   (accept),
    .en    (!idle),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    os_d         = os_q;
    bit_d        = bit_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (idle) begin
      if (accept) begin
        state_d      = START;
        shift_d      = sel1 ? req.req1_data : req.req0_data;
        grant_d      = sel1;
        last_grant_d = sel1;
        os_d         = '0;
        bit_d        = '0;
      end
    end else if (tick) begin
      if (os_q != OS_LAST) begin
        os_d = os_q + 1'b1;
      end else begin
        os_d = '0;
        unique case (state_q)
          START: state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          STOP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q      <= IDLE;
      os_q         <= '0;
      bit_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      os_q         <= os_d;
      bit_q        <= bit_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: the shifter is pure datapath, always loaded before it is read, so it
  // carries no reset.
  always_ff @(posedge clkin) begin
    shift_q <= shift_d;
  end

  always_comb begin
    unique case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = shift_q[0];
      default: txd = 1'b1;
    endcase
    busy  = !idle;
    grant = grant_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a CLK_DIV=4 instance for arbitration, reset and random
// traffic, and a default-divider instance for the full-length frame.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int FAST_DIV = 4;
  localparam int OS       = 16;
  localparam int DW       = 8;
  localparam int NV       = 9;

  logic clkin = 1'b0;
  logic rst_f, rst_s;
  logic txd_f, busy_f, grant_f;
  logic txd_s, busy_s, grant_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkin = ~clkin;

  uart_tx_arbiter_if #(.DATA_W(DW)) bus_f ();
  uart_tx_arbiter_if #(.DATA_W(DW)) bus_s ();

  uart_tx_arbiter #(.CLK_DIV(FAST_DIV), .OVERSAMPLE(OS), .DATA_W(DW)) dut_f (
    .clkin (clkin), .rst (rst_f), .req (bus_f),
    .txd (txd_f), .busy (busy_f), .grant (grant_f)
  );

  uart_tx_arbiter dut_s (
    .clkin (clkin), .rst (rst_s), .req (bus_s),
    .txd (txd_s), .busy (busy_s), .grant (grant_s)
  );

  typedef struct {
    bit         do_rst;
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         exp_r0;
    bit         exp_r1;
    bit         exp_grant;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line level k cycles after acceptance: start bit, LSB-first data, then stop/idle high.
  function automatic logic exp_txd(input logic [7:0] b, input int k, input int bitlen);
    int pos;
    pos = k / bitlen;
    if (pos == 0) return 1'b0;
    if (pos <= DW) return b[pos-1];
    return 1'b1;
  endfunction

  task automatic drive_f(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1);
    bus_f.req0_valid = v0;
    bus_f.req1_valid = v1;
    bus_f.req0_data  = d0;
    bus_f.req1_data  = d1;
  endtask

  task automatic do_reset_f();
    rst_f = 1'b1;
    @(negedge clkin); #1;
    rst_f = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns #1 after the negedge of the first idle cycle.
  task automatic check_frame(input logic [7:0] b, input logic g, input bit slow,
                             input bit jitter, input string tag, output int low_cnt);
    int bitlen, flen, bad_txd, busy_cnt, bad_grant, bad_rdy;
    logic t, bz, gr, r0, r1;
    bitlen = OS * (slow ? DEF_CLK_DIV : FAST_DIV);
    flen = (DW + 2) * bitlen;
    bad_txd = 0; busy_cnt = 0; bad_grant = 0; bad_rdy = 0; low_cnt = 0;
    for (int k = 0; k <= flen; k++) begin
      @(negedge clkin);
      if (jitter && k < flen)
        drive_f(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
      #1;
      t  = slow ? txd_s : txd_f;
      bz = slow ? busy_s : busy_f;
      gr = slow ? grant_s : grant_f;
      r0 = slow ? bus_s.req0_ready : bus_f.req0_ready;
      r1 = slow ? bus_s.req1_ready : bus_f.req1_ready;
      if (t !== exp_txd(b, k, bitlen)) bad_txd++;
      if (gr !== g) bad_grant++;
      if (k < flen) begin
        if (bz === 1'b1) busy_cnt++;
        if (t === 1'b0) low_cnt++;
        if (r0 !== 1'b0 || r1 !== 1'b0) bad_rdy++;
      end else begin
        check({tag, "_busy_fall"}, bz, 1'b0);
      end
    end
    check({tag, "_txd_errs"}, bad_txd, 0);
    check({tag, "_busy_cycles"}, busy_cnt, flen);
    check({tag, "_grant_errs"}, bad_grant, 0);
    check({tag, "_ready_while_busy"}, bad_rdy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   lc, bad, gap, w;
    logic last_g;
    logic v0, v1;
    logic [7:0] d0, d1;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b1, 8'h34};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h56, 8'h78, 1'b1, 1'b0, 1'b0, 8'h56};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h9A, 1'b0, 1'b1, 1'b1, 8'h9A};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hBC, 1'b0, 1'b1, 1'b1, 8'hBC};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 8'hDE, 8'hF0, 1'b1, 1'b0, 1'b0, 8'hDE};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F};

    rst_f = 1'b1;
    rst_s = 1'b1;
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);
    bus_s.req0_valid = 1'b0;
    bus_s.req1_valid = 1'b0;
    bus_s.req0_data  = 8'h00;
    bus_s.req1_data  = 8'h00;

    // Ready must stay low while reset is held, even with requests pending.
    repeat (3) @(negedge clkin);
    drive_f(1'b1, 1'b1, 8'h11, 8'h22);
    #1;
    check("ready0_in_reset", bus_f.req0_ready, 1'b0);
    check("ready1_in_reset", bus_f.req1_ready, 1'b0);
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);
    rst_f = 1'b0;
    rst_s = 1'b0;
    #1;
    check("reset_txd", txd_f, 1'b1);
    check("reset_busy", busy_f, 1'b0);
    check("reset_grant", grant_f, 1'b0);
    check("reset_ready0", bus_f.req0_ready, 1'b0);
    check("reset_ready1", bus_f.req1_ready, 1'b0);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin); #1;
      if (txd_f !== 1'b1 || busy_f !== 1'b0 || grant_f !== 1'b0 ||
          bus_f.req0_ready !== 1'b0 || bus_f.req1_ready !== 1'b0) bad++;
    end
    check("idle_hold_errs", bad, 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_rst) do_reset_f();
      drive_f(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1);
      #1;
      check($sformatf("vec%0d_ready0", i), bus_f.req0_ready, vecs[i].exp_r0);
      check($sformatf("vec%0d_ready1", i), bus_f.req1_ready, vecs[i].exp_r1);
      @(posedge clkin); #1;
      drive_f(1'b0, 1'b0, 8'h00, 8'h00);
      check_frame(vecs[i].exp_byte, vecs[i].exp_grant, 1'b0, 1'b0,
                  $sformatf("vec%0d", i), lc);
    end

    // Both requesters held valid: grants alternate and the loser is taken the cycle busy falls.
    do_reset_f();
    last_g = 1'b1;
    drive_f(1'b1, 1'b1, 8'hA5, 8'h3C);
    for (int f = 0; f < 4; f++) begin
      w = (last_g == 1'b1) ? 0 : 1;
      #1;
      check($sformatf("held%0d_ready0", f), bus_f.req0_ready, 1'(w == 0));
      check($sformatf("held%0d_ready1", f), bus_f.req1_ready, 1'(w == 1));
      @(posedge clkin); #1;
      last_g = 1'(w);
      check_frame((w == 1) ? 8'h3C : 8'hA5, 1'(w), 1'b0, 1'b0,
                  $sformatf("held%0d", f), lc);
    end
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during data bit 3 abandons the frame; the next request gets a full start bit.
    do_reset_f();
    drive_f(1'b1, 1'b0, 8'h55, 8'h00);
    #1;
    check("midrst_ready0", bus_f.req0_ready, 1'b1);
    @(posedge clkin); #1;
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);
    bad = 0;
    for (int k = 0; k < 280; k++) begin
      @(negedge clkin); #1;
      if (txd_f !== exp_txd(8'h55, k, OS * FAST_DIV) || busy_f !== 1'b1) bad++;
    end
    check("midrst_pre_errs", bad, 0);
    rst_f = 1'b1;
    @(negedge clkin); #1;
    check("midrst_txd", txd_f, 1'b1);
    check("midrst_busy", busy_f, 1'b0);
    check("midrst_grant", grant_f, 1'b0);
    rst_f = 1'b0;
    drive_f(1'b0, 1'b1, 8'h00, 8'hFF);
    #1;
    check("postrst_ready1", bus_f.req1_ready, 1'b1);
    check("postrst_ready0", bus_f.req0_ready, 1'b0);
    @(posedge clkin); #1;
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);
    check_frame(8'hFF, 1'b1, 1'b0, 1'b0, "postrst", lc);

    // Random traffic against the round-robin rule, with valids toggling during frames.
    do_reset_f();
    last_g = 1'b1;
    for (int f = 0; f < 12; f++) begin
      drive_f(1'b0, 1'b0, 8'h00, 8'h00);
      gap = $urandom_range(0, 3);
      bad = 0;
      for (int i = 0; i < gap; i++) begin
        @(negedge clkin); #1;
        if (busy_f !== 1'b0 || txd_f !== 1'b1) bad++;
      end
      check($sformatf("rand%0d_gap_errs", f), bad, 0);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v1 = 1'b1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      w = (v0 && v1) ? ((last_g == 1'b1) ? 0 : 1) : (v1 ? 1 : 0);
      drive_f(v0, v1, d0, d1);
      #1;
      check($sformatf("rand%0d_ready0", f), bus_f.req0_ready, 1'(w == 0));
      check($sformatf("rand%0d_ready1", f), bus_f.req1_ready, 1'(w == 1));
      @(posedge clkin); #1;
      last_g = 1'(w);
      drive_f(1'b0, 1'b0, 8'h00, 8'h00);
      check_frame((w == 1) ? d1 : d0, 1'(w), 1'b0, 1'b1, $sformatf("rand%0d", f), lc);
    end
    drive_f(1'b0, 1'b0, 8'h00, 8'h00);

    // Default divider: one 0x00 frame, 9 low bits then one stop bit.
    bus_s.req0_valid = 1'b1;
    bus_s.req0_data  = 8'h00;
    #1;
    check("slow_ready0", bus_s.req0_ready, 1'b1);
    @(posedge clkin); #1;
    bus_s.req0_valid = 1'b0;
    check_frame(8'h00, 1'b0, 1'b1, 1'b0, "slow", lc);
    check("slow_low_cycles", lc, 46944);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmitter between two byte requesters in the UART path. Arbitrates round-robin, serialises the granted byte at 16× oversampling, and owns the bit-timing tick (clkin divided by CLK_DIV, 325.52 → 326 at 50 MHz / 9600 baud). Single clock domain; the tick is a clock enable, not a derived clock.

## Interface
- CLK_DIV, 326: clkin cycles per sample tick; must be ≥ 2.
- OVERSAMPLE, 16: sample ticks per bit.
- DATA_W, 8: data bits per frame.
- clkin  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a byte.
- req0_data  in  DATA_W  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte.
- req1_data  in  DATA_W  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- txd  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- grant  out  1  owner of current/last frame (0 = req0, 1 = req1).

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: txd=1, busy=0. Requester selection:
  - Only one valid: that one wins.
  - Both valid: the one not granted last (last_grant register) wins.
- Winner's ready is combinational: state==IDLE && valid && selected. Acceptance = valid&&ready at a clkin edge. On acceptance:
  - latch data into a shift register;
  - update grant and last_grant;
  - clear tick divider, oversample counter and bit index;
  - go to START.
- Valid must not depend on ready. Valid may drop before acceptance without effect.
- START: txd=0 for OVERSAMPLE ticks, then DATA.
- DATA: DATA_W bits, LSB first, OVERSAMPLE ticks each, then STOP.
- STOP: txd=1 for OVERSAMPLE ticks, then IDLE.
- The tick divider counts 0..CLK_DIV-1 and pulses tick on terminal count. It runs only outside IDLE.
- Counter widths:
  - divider: $clog2(CLK_DIV);
  - oversample: $clog2(OVERSAMPLE);
  - bit index: $clog2(DATA_W).
  - All wrap to 0 at terminal count, never free-run past it.
- Reset (any state, including mid-frame): on the next edge state=IDLE, txd=1, busy=0, grant=0, last_grant=1 (req0 wins the first tie), counters=0. Both ready outputs read 0 during reset. The abandoned frame is never resumed.

## Timing
- Accept at edge T: txd=0 and busy=1 from T+1.
- Each bit lasts exactly OVERSAMPLE×CLK_DIV cycles.
- Full frame is (DATA_W+2)×OVERSAMPLE×CLK_DIV cycles: 52160 at defaults.
- busy falls in the cycle after the last stop-bit cycle. That same cycle is IDLE, so a pending request is accepted immediately. The back-to-back gap is 1 cycle of idle-high txd beyond the stop bit.
- ready pulses exactly one cycle per accepted byte.
- ready is never high when busy=1.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the default CLK_DIV/OVERSAMPLE constants;
  - a helper function computing CLK_DIV from clock frequency and baud.
- Sub-module uart_tick_gen: parameter CLK_DIV; inputs clkin, rst, clr, en; output tick (1-cycle pulse).
- Arbiter, FSM and shifter stay in the top module.

## Test plan
- Reset → txd=1, busy=0, grant=0, both ready=0. Hold for 100 cycles with no request → no change.
- CLK_DIV=4, req0 sends 0x55 → one req0_ready pulse. txd sequence, 64 cycles each:
  - start bit 0;
  - data 1,0,1,0,1,0,1,0;
  - stop bit 1.
  - busy high for exactly 640 cycles.
- CLK_DIV=4, both valid at the same edge after reset (req0=0xA5, req1=0x3C):
  - first frame 0xA5 with grant=0;
  - req1_ready pulses the cycle after busy falls;
  - second frame 0x3C with grant=1.
- Both held valid continuously for 4 frames → grant sequence 0,1,0,1. No starvation.
- CLK_DIV=4, rst asserted for 1 cycle during data bit 3:
  - next edge: txd=1, busy=0;
  - a following req1 0xFF is accepted and gets a full 64-cycle start bit.
- Defaults (CLK_DIV=326), single byte 0x00 → start+8 data bits low for 46944 cycles, stop high for 5216. Total busy = 52160 cycles.
